// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared LSU definitions: FSM states, funct3 size codes, lane masks and
// the size/alignment decode used by both the control path and the aligner.
package ysyx_23060201_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;

    // Unlisted funct3 codes fall through to word size.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] base_mask(input lsu_size_e size);
        case (size)
            SZ_BYTE: return MASK_B;
            SZ_HALF: return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Lane aligner: byte-enable mask, store data shift and load data extraction
// with sign/zero extension. Purely combinational.
module ysyx_23060201_LSU_ALIGN
    import ysyx_23060201_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [7:0]  mask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    lsu_size_e   size;
    logic        sgn;
    logic [4:0]  sh;
    logic [31:0] rdata_sh;

    always_comb begin
        size     = f3_size(funct3);
        sgn      = f3_signed(funct3);
        sh       = {addr, 3'b000};
        mask     = base_mask(size) << addr;
        wdata_sh = wdata << sh;
        rdata_sh = rdata >> sh;
        case (size)
            SZ_BYTE: rdata_ext = sgn ? {{24{rdata_sh[7]}}, rdata_sh[7:0]}
                                     : {24'h000000, rdata_sh[7:0]};
            SZ_HALF: rdata_ext = sgn ? {{16{rdata_sh[15]}}, rdata_sh[15:0]}
                                     : {16'h0000, rdata_sh[15:0]};
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_lsu_reg.sv
// Common holding register primitive, asynchronous active-low reset variant.
module ysyx_23060201_Reg #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one EXU request, performs a single-cycle memory
// access, and holds the aligned/extended result for the WBU handshake.
module ysyx_23060201_lsu
    import ysyx_23060201_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [4:0]            in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [4:0]            out_rd,
    output logic                  out_err,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]            mem_rmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int unsigned REQ_W = 2 + 3 + ADDR_WIDTH + DATA_WIDTH + 5;

    lsu_state_e state_q, state_d;

    logic                  accept;
    logic                  in_mis;
    logic                  in_mem_op;
    logic                  in_st_only;
    logic                  in_err;
    logic [REQ_W-1:0]      req_q;
    logic                  ld_q, st_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic                  in_access;
    logic [7:0]            lane_mask;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rdata_ext;
    logic                  rdata_wen;
    logic [DATA_WIDTH-1:0] rdata_d;

    assign accept     = in_valid & in_ready;
    assign in_mem_op  = in_load | in_store;
    assign in_mis     = misaligned(in_funct3, in_addr[1:0]);
    assign in_err     = in_mem_op & in_mis;
    // Load wins if both flags are set, so ren and wen can never coincide.
    assign in_st_only = in_store & ~in_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        in_access = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_mem_op && !in_mis) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                in_access = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ysyx_23060201_Reg #(
        .WIDTH    (REQ_W),
        .RESET_VAL('0)
    ) u_req_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .wen  (accept),
        .din  ({in_load, in_st_only, in_funct3, in_addr, in_wdata, in_rd}),
        .dout (req_q)
    );

    assign {ld_q, st_q, f3_q, addr_q, wdata_q, rd_q} = req_q;

    ysyx_23060201_LSU_ALIGN u_align (
        .funct3   (f3_q),
        .addr     (addr_q[1:0]),
        .wdata    (wdata_q),
        .rdata    (mem_rdata),
        .mask     (lane_mask),
        .wdata_sh (wdata_sh),
        .rdata_ext(rdata_ext)
    );

    // Result is cleared on accept so stores, errors and no-ops report zero.
    assign rdata_wen = accept | (in_access & ld_q);
    assign rdata_d   = accept ? '0 : rdata_ext;

    ysyx_23060201_Reg #(
        .WIDTH    (DATA_WIDTH),
        .RESET_VAL('0)
    ) u_rdata_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .wen  (rdata_wen),
        .din  (rdata_d),
        .dout (out_rdata)
    );

    ysyx_23060201_Reg #(
        .WIDTH    (1),
        .RESET_VAL(1'b0)
    ) u_err_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .wen  (accept),
        .din  (in_err),
        .dout (out_err)
    );

    assign out_rd    = rd_q;
    assign mem_ren   = in_access & ld_q;
    assign mem_wen   = in_access & st_q;
    assign mem_raddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_waddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_rmask = mem_ren ? lane_mask : '0;
    assign mem_wmask = mem_wen ? lane_mask : '0;
    assign mem_wdata = wdata_sh;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Bench for ysyx_23060201_lsu: directed vector table, randomized requests
// against an arithmetic reference model, and a reset-during-access sequence.
module tb_ysyx_23060201_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_err;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [7:0]  mem_rmask;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_wdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string     nm;
        bit        ld;
        bit        st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [4:0]  rd;
        bit [31:0] rdata;
        int        stall;
        bit [31:0] exp_rdata;
        bit        exp_err;
        bit [7:0]  exp_mask;
        bit [31:0] exp_maddr;
        bit [31:0] exp_mwdata;
    } vec_t;

    ysyx_23060201_lsu #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_load  (in_load),
        .in_store (in_store),
        .in_funct3(in_funct3),
        .in_addr  (in_addr),
        .in_wdata (in_wdata),
        .in_rd    (in_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rdata(out_rdata),
        .out_rd   (out_rd),
        .out_err  (out_err),
        .mem_ren  (mem_ren),
        .mem_raddr(mem_raddr),
        .mem_rmask(mem_rmask),
        .mem_rdata(mem_rdata),
        .mem_wen  (mem_wen),
        .mem_waddr(mem_waddr),
        .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input string nm, input bit ld, input bit st, input bit [2:0] f3,
                                input bit [31:0] addr, input bit [31:0] wdata, input bit [31:0] rdata,
                                input int stall, input bit [31:0] e_rdata, input bit e_err,
                                input bit [7:0] e_mask, input bit [31:0] e_maddr,
                                input bit [31:0] e_mwdata);
        vec_t v;
        v.nm = nm; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rd = 5'd0; v.rdata = rdata; v.stall = stall;
        v.exp_rdata = e_rdata; v.exp_err = e_err; v.exp_mask = e_mask;
        v.exp_maddr = e_maddr; v.exp_mwdata = e_mwdata;
        return v;
    endfunction

    // Reference: size in bytes, offset within the word, and plain integer
    // arithmetic for lane shifting and extension.
    function automatic vec_t model(input vec_t v);
        vec_t   e;
        int     size;
        int     off;
        bit     sgn;
        bit     mis;
        bit     acc;
        longint r;
        longint lim;
        e    = v;
        size = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        sgn  = (v.f3 == 3'd0 || v.f3 == 3'd1);
        off  = int'(v.addr % 32'd4);
        mis  = (off % size) != 0;
        acc  = (v.ld || v.st) && !mis;
        e.exp_err    = (v.ld || v.st) && mis;
        e.exp_mask   = acc ? 8'(((1 << size) - 1) << off) : 8'h00;
        e.exp_maddr  = 32'(longint'(v.addr) - longint'(off));
        e.exp_mwdata = 32'((longint'(v.wdata) * (longint'(1) << (8 * off))) % (longint'(1) << 32));
        e.exp_rdata  = 32'd0;
        if (acc && v.ld) begin
            lim = longint'(1) << (8 * size);
            r   = (longint'(v.rdata) / (longint'(1) << (8 * off))) % lim;
            if (sgn && r >= lim / 2) r = r - lim;
            e.exp_rdata = 32'(r);
        end
        return e;
    endfunction

    task automatic run_txn(input vec_t v);
        int  n;
        int  lat;
        int  ren_cnt;
        int  wen_cnt;
        bit  acc;
        acc = (v.exp_mask != 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        chk({v.nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
        chk({v.nm, " out_valid_idle"}, 32'(out_valid), 32'd0);

        in_valid  = 1'b1;
        in_load   = v.ld;
        in_store  = v.st;
        in_funct3 = v.f3;
        in_addr   = v.addr;
        in_wdata  = v.wdata;
        in_rd     = v.rd;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_load   = 1'($urandom);
        in_store  = 1'($urandom);
        in_funct3 = 3'($urandom);
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_rd     = 5'($urandom);
        mem_rdata = v.rdata;

        lat = 0; ren_cnt = 0; wen_cnt = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            chk({v.nm, " in_ready_busy"}, 32'(in_ready), 32'd0);
            chk({v.nm, " ren_and_wen"}, 32'(mem_ren & mem_wen), 32'd0);
            if (mem_ren) begin
                ren_cnt++;
                chk({v.nm, " raddr"}, mem_raddr, v.exp_maddr);
                chk({v.nm, " rmask"}, 32'(mem_rmask), 32'(v.exp_mask));
            end else if (mem_wen) begin
                wen_cnt++;
                chk({v.nm, " waddr"}, mem_waddr, v.exp_maddr);
                chk({v.nm, " wmask"}, 32'(mem_wmask), 32'(v.exp_mask));
                chk({v.nm, " wdata"}, mem_wdata, v.exp_mwdata);
            end else begin
                chk({v.nm, " idle_masks"}, 32'({mem_rmask, mem_wmask}), 32'd0);
            end
            if (out_valid) break;
        end
        mem_rdata = $urandom;
        chk({v.nm, " latency"}, 32'(lat), acc ? 32'd2 : 32'd1);
        chk({v.nm, " ren_pulses"}, 32'(ren_cnt), (acc && v.ld) ? 32'd1 : 32'd0);
        chk({v.nm, " wen_pulses"}, 32'(wen_cnt), (acc && v.st && !v.ld) ? 32'd1 : 32'd0);
        chk({v.nm, " out_rdata"}, out_rdata, v.exp_rdata);
        chk({v.nm, " out_err"}, 32'(out_err), 32'(v.exp_err));
        chk({v.nm, " out_rd"}, 32'(out_rd), 32'(v.rd));

        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk({v.nm, " stall_valid"}, 32'(out_valid), 32'd1);
            chk({v.nm, " stall_in_ready"}, 32'(in_ready), 32'd0);
            chk({v.nm, " stall_rdata"}, out_rdata, v.exp_rdata);
            chk({v.nm, " stall_err_rd"}, 32'({out_err, out_rd}), 32'({v.exp_err, v.rd}));
            chk({v.nm, " stall_no_access"}, 32'(mem_ren | mem_wen), 32'd0);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({v.nm, " ret_valid"}, 32'(out_valid), 32'd0);
        chk({v.nm, " ret_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t dir[13];
    vec_t rv;
    int   kind;
    int   off;

    initial begin
        dir[0]  = mk("lw_align",   1, 0, 3'b010, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 0,
                     32'hDEAD_BEEF, 0, 8'h0F, 32'h8000_0004, 32'h0);
        dir[1]  = mk("lb_sign",    1, 0, 3'b000, 32'h8000_0003, 32'h0,         32'h8000_0000, 0,
                     32'hFFFF_FF80, 0, 8'h08, 32'h8000_0000, 32'h0);
        dir[2]  = mk("lbu_zero",   1, 0, 3'b100, 32'h8000_0003, 32'h0,         32'h8000_0000, 0,
                     32'h0000_0080, 0, 8'h08, 32'h8000_0000, 32'h0);
        dir[3]  = mk("sh_lane2",   0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0,         0,
                     32'h0,         0, 8'h0C, 32'h8000_0000, 32'hABCD_0000);
        dir[4]  = mk("lw_misal",   1, 0, 3'b010, 32'h8000_0001, 32'h0,         32'hFFFF_FFFF, 0,
                     32'h0,         1, 8'h00, 32'h0,         32'h0);
        dir[5]  = mk("lh_stall",   1, 0, 3'b001, 32'h8000_0000, 32'h0,         32'h0000_7FFF, 5,
                     32'h0000_7FFF, 0, 8'h03, 32'h8000_0000, 32'h0);
        dir[6]  = mk("noop",       0, 0, 3'b010, 32'h8000_0010, 32'h0,         32'hAAAA_5555, 0,
                     32'h0,         0, 8'h00, 32'h0,         32'h0);
        dir[7]  = mk("f3_011",     1, 0, 3'b011, 32'h8000_0008, 32'h0,         32'h8123_4567, 0,
                     32'h8123_4567, 0, 8'h0F, 32'h8000_0008, 32'h0);
        dir[8]  = mk("sb_lane1",   0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0,         0,
                     32'h0,         0, 8'h02, 32'h8000_0000, 32'h0000_A500);
        dir[9]  = mk("lhu_lane2",  1, 0, 3'b101, 32'h8000_0002, 32'h0,         32'hF00D_1234, 0,
                     32'h0000_F00D, 0, 8'h0C, 32'h8000_0000, 32'h0);
        dir[10] = mk("sw_misal",   0, 1, 3'b010, 32'h8000_0002, 32'h1122_3344, 32'h0,         2,
                     32'h0,         1, 8'h00, 32'h0,         32'h0);
        dir[11] = mk("lh_misal",   1, 0, 3'b001, 32'h8000_0003, 32'h0,         32'h1234_5678, 0,
                     32'h0,         1, 8'h00, 32'h0,         32'h0);
        dir[12] = mk("lh_neg",     1, 0, 3'b001, 32'h8000_0006, 32'h0,         32'h9ABC_0000, 1,
                     32'hFFFF_9ABC, 0, 8'h0C, 32'h8000_0004, 32'h0);

        rst_n = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_funct3 = 3'd0;
        in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; out_ready = 1'b0; mem_rdata = 32'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_bits", 32'({out_err, out_rd}), 32'd0);
        chk("reset out_rdata", out_rdata, 32'd0);
        chk("reset mem_en", 32'({mem_ren, mem_wen}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            dir[i].rd = 5'(i + 1);
            run_txn(dir[i]);
        end

        for (int i = 0; i < 64; i++) begin
            kind     = $urandom_range(0, 9);
            rv.nm    = $sformatf("rand%0d", i);
            rv.ld    = (kind < 5);
            rv.st    = (kind >= 5 && kind < 9);
            rv.f3    = rv.st ? 3'($urandom_range(0, 2)) : 3'($urandom);
            off      = (rv.ld || rv.st) ? $urandom_range(0, 3) : 0;
            rv.addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | 32'(off);
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.rd    = 5'($urandom);
            rv.stall = $urandom_range(0, 3);
            run_txn(model(rv));
        end

        // Reset while in ACCESS: the access must vanish at once and the
        // next request must run normally.
        @(negedge clk);
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'b010;
        in_addr = 32'h8000_0008; in_rd = 5'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("rst_mid pre_ren", 32'(mem_ren), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid mem_en", 32'({mem_ren, mem_wen}), 32'd0);
        chk("rst_mid out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid out_rdata", out_rdata, 32'd0);
        chk("rst_mid out_bits", 32'({out_err, out_rd}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_after quiet", 32'({mem_ren, mem_wen, out_valid}), 32'd0);
        end
        run_txn(mk("post_rst_lw", 1, 0, 3'b010, 32'h8000_000C, 32'h0, 32'hCAFE_F00D, 1,
                   32'hCAFE_F00D, 0, 8'h0F, 32'h8000_000C, 32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060201_lsu.md
YSYX_23060201_LSU -- requirements
Module: ysyx_23060201_LSU

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data-path width; only 32 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have the following upstream (EXU) ports:
- in_valid, input, 1: request valid.
- in_ready, output, 1: LSU can accept.
- in_load, input, 1: load operation.
- in_store, input, 1: store operation.
- in_funct3, input, 3: RV32 size/sign code (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010).
- in_addr, input, ADDR_WIDTH: byte address.
- in_wdata, input, DATA_WIDTH: store data, right-aligned.
- in_rd, input, 5: destination register tag.
REQ-006 The block SHALL have the following downstream (WBU) ports:
- out_valid, output, 1: response valid.
- out_ready, input, 1: consumer accepts.
- out_rdata, output, DATA_WIDTH: extended load data.
- out_rd, output, 5: echoed tag.
- out_err, output, 1: misaligned access.
REQ-007 The block SHALL have the following memory-side ports:
- mem_ren, output, 1.
- mem_raddr, output, ADDR_WIDTH.
- mem_rmask, output, 8.
- mem_rdata, input, DATA_WIDTH: combinational read data.
- mem_wen, output, 1.
- mem_waddr, output, ADDR_WIDTH.
- mem_wmask, output, 8.
- mem_wdata, output, DATA_WIDTH.

Function
REQ-008 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-009 In IDLE, in_ready SHALL be 1 and out_valid 0; every other state SHALL hold in_ready at 0.
REQ-010 A request SHALL be accepted on the edge where in_valid&in_ready is true; at that edge in_load, in_store, in_funct3, in_addr, in_wdata and in_rd SHALL be latched.
REQ-011 For an aligned load or store, the FSM SHALL go from IDLE to ACCESS.
REQ-012 For a misaligned access, or a request with neither in_load nor in_store set, the FSM SHALL go from IDLE directly to RESP.
REQ-013 Misalignment SHALL be defined as: halfword with addr[0]=1, or word with addr[1:0]!=0; it SHALL set out_err=1 and SHALL issue no memory access.
REQ-014 ACCESS SHALL last exactly one cycle, asserting mem_ren (load) or mem_wen (store), never both.
REQ-015 mem_raddr and mem_waddr SHALL equal the latched addr with bits [1:0] cleared.
REQ-016 The base mask SHALL be 8'h01 for byte, 8'h03 for halfword and 8'h0F for word; mem_rmask and mem_wmask SHALL equal the base mask shifted left by addr[1:0].
REQ-017 mem_wdata SHALL equal the latched wdata shifted left by 8*addr[1:0].
REQ-018 On the ACCESS edge the LSU SHALL capture mem_rdata shifted right by 8*addr[1:0], then sign-extend it (LB, LH) or zero-extend it (LBU, LHU); LW SHALL pass unchanged. The result SHALL be held in out_rdata.
REQ-019 out_rdata SHALL be 0 for stores, for errors and for no-op requests.
REQ-020 In RESP, out_valid SHALL be 1 and out_rdata, out_rd and out_err SHALL be stable until out_valid&out_ready.
REQ-021 On out_valid&out_ready the FSM SHALL return to IDLE; it SHALL not accept a new request in the same cycle.
REQ-022 Latency SHALL be: accept at edge N, mem access during cycle N+1, out_valid during cycle N+2; a stalled out_ready SHALL extend RESP indefinitely.
REQ-023 mem_ren, mem_wen, mem_rmask and mem_wmask SHALL be 0 in every state except ACCESS.
REQ-024 A funct3 value outside the listed codes SHALL be treated as a word access.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE and out_valid, out_err, out_rdata, out_rd, mem_ren and mem_wen SHALL be 0, independent of clk.
REQ-026 Reset asserted during ACCESS or RESP SHALL abandon the transaction; no memory access SHALL be issued after the reset edge.
REQ-027 The first accept SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-028 The state encoding, funct3 size codes and base-mask constants SHALL reside in the shared package / defines header.
REQ-029 Lane alignment and extraction SHALL be one combinational sub-module, ysyx_23060201_LSU_ALIGN (inputs: funct3, addr[1:0], wdata, rdata; outputs: mask, shifted wdata, extended rdata).
REQ-030 Holding registers SHALL use the codebase's common Reg primitive with an asynchronous-reset variant.

Verification
REQ-031 Test: LW at 0x8000_0004, with mem_rdata=0xDEAD_BEEF. Required: mem_raddr=0x8000_0004, rmask=0x0F, out_rdata=0xDEAD_BEEF, out_valid 2 cycles after accept.
REQ-032 Test: LB at 0x8000_0003, with mem_rdata=0x8000_0000. Required: rmask=0x08, out_rdata=0xFFFF_FF80. Test LBU with the same stimulus: required out_rdata=0x0000_0080.
REQ-033 Test: SH of wdata 0x1234_ABCD at 0x8000_0002. Required: mem_waddr=0x8000_0000, wmask=0x0C, mem_wdata=0xABCD_0000, one mem_wen pulse.
REQ-034 Test: LW at 0x8000_0001. Required: no mem_ren, out_err=1, out_rdata=0, out_valid 1 cycle after accept.
REQ-035 Test: hold out_ready=0 for 5 cycles after a LH returning 0x0000_7FFF. Required: out_rdata=0x0000_7FFF stable, in_ready=0 throughout, single access.
REQ-036 Test: assert rst_n=0 mid-ACCESS. Required: mem_ren/mem_wen drop immediately, state IDLE, out_valid=0, and the next request completes normally.
